// File: rtl/rv32_alu_issue.sv
// RV32I issue stage: decodes OP / OP-IMM / BRANCH, selects operands, registers a one-hot ALU op.
// Latency: 1 cycle from input handshake to out_valid; full throughput in both build variants.
// Backpressure: output held while !out_ready; in_ready is combinational by default, or a flop
//   driven from a 2-entry skid buffer when ALU_ISSUE_SKID_EN is defined.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   upstream handshake; in_instr, in_pc, in_rs1_data, in_rs2_data payload
//   out_valid / out_ready downstream handshake towards the ALU
//   reg_op1, reg_op2      ALU operands (rs1; rs2, sign-extended immediate or shamt)
//   out_op                one-hot ALU op: 0 add,1 sub,2 and,3 or,4 xor,5 sll,6 srl,7 sra,
//                         8 slt,9 sltu,10 beq,11 bne,12 blt,13 bge,14 bltu,15 bgeu
//   out_br_imm            sign-extended B-type offset (0 for non-branch)
//   out_pc                PC of the issued instruction
//   out_illegal           issued word is not a supported OP / OP-IMM / BRANCH
// Build option: ALU_ISSUE_SKID_EN selects the registered-ready skid buffer variant.
module rv32_alu_issue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] reg_op1,
  output logic [XLEN-1:0] reg_op2,
  output logic [15:0]     out_op,
  output logic [XLEN-1:0] out_br_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  if (XLEN != 32) begin : g_xlen_chk
    $error("rv32_alu_issue: only XLEN=32 is supported");
  end

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_SLL  = 5;
  localparam int OP_SRL  = 6;
  localparam int OP_SRA  = 7;
  localparam int OP_SLT  = 8;
  localparam int OP_SLTU = 9;
  localparam int OP_BEQ  = 10;
  localparam int OP_BNE  = 11;
  localparam int OP_BLT  = 12;
  localparam int OP_BGE  = 13;
  localparam int OP_BLTU = 14;
  localparam int OP_BGEU = 15;

  typedef struct packed {
    logic [15:0]     op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] br_imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } iss_t;

  // ------------------------------------------------------------------
  // Decode (pure function of the offered word; only captured on accept,
  // so X on in_* while !in_valid never reaches state)
  // ------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_shamt;
  logic [XLEN-1:0] imm_b;
  iss_t            dec;

  assign opcode    = in_instr[6:0];
  assign funct3    = in_instr[14:12];
  assign funct7    = in_instr[31:25];
  assign imm_i     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_shamt = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  assign imm_b     = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};

  // rs1 index field is resolved upstream; the register value arrives on in_rs1_data
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^in_instr[19:15];

  always_comb begin
    dec         = '0;
    dec.op1     = in_rs1_data;
    dec.op2     = in_rs2_data;
    dec.pc      = in_pc;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: dec.op[OP_ADD]  = 1'b1;
            3'b001: dec.op[OP_SLL]  = 1'b1;
            3'b010: dec.op[OP_SLT]  = 1'b1;
            3'b011: dec.op[OP_SLTU] = 1'b1;
            3'b100: dec.op[OP_XOR]  = 1'b1;
            3'b101: dec.op[OP_SRL]  = 1'b1;
            3'b110: dec.op[OP_OR]   = 1'b1;
            3'b111: dec.op[OP_AND]  = 1'b1;
            default: dec.illegal    = 1'b1;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec.op[OP_SUB] = 1'b1;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec.op[OP_SRA] = 1'b1;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // funct7 only qualifies the shifts; there is no subtract-immediate
        case (funct3)
          3'b000: begin dec.op[OP_ADD]  = 1'b1; dec.op2 = imm_i; end
          3'b010: begin dec.op[OP_SLT]  = 1'b1; dec.op2 = imm_i; end
          3'b011: begin dec.op[OP_SLTU] = 1'b1; dec.op2 = imm_i; end
          3'b100: begin dec.op[OP_XOR]  = 1'b1; dec.op2 = imm_i; end
          3'b110: begin dec.op[OP_OR]   = 1'b1; dec.op2 = imm_i; end
          3'b111: begin dec.op[OP_AND]  = 1'b1; dec.op2 = imm_i; end
          3'b001: begin
            if (funct7 == F7_BASE) begin
              dec.op[OP_SLL] = 1'b1;
              dec.op2        = imm_shamt;
            end else begin
              dec.illegal = 1'b1;
            end
          end
          3'b101: begin
            if (funct7 == F7_BASE) begin
              dec.op[OP_SRL] = 1'b1;
              dec.op2        = imm_shamt;
            end else if (funct7 == F7_ALT) begin
              dec.op[OP_SRA] = 1'b1;
              dec.op2        = imm_shamt;
            end else begin
              dec.illegal = 1'b1;
            end
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        dec.br_imm = imm_b;
        case (funct3)
          3'b000: dec.op[OP_BEQ]  = 1'b1;
          3'b001: dec.op[OP_BNE]  = 1'b1;
          3'b100: dec.op[OP_BLT]  = 1'b1;
          3'b101: dec.op[OP_BGE]  = 1'b1;
          3'b110: dec.op[OP_BLTU] = 1'b1;
          3'b111: dec.op[OP_BGEU] = 1'b1;
          default: begin
            dec.illegal = 1'b1;
            dec.br_imm  = '0;
          end
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // ------------------------------------------------------------------
  // Output register and flow control
  // ------------------------------------------------------------------
  iss_t out_q;
  logic accept;

`ifdef ALU_ISSUE_SKID_EN
  // Skid variant: in_ready comes straight from a flop. While the output is
  // stalled, accepted entries queue in skid_q (slot 0 is the oldest) and are
  // always moved to the output before any newer incoming entry.
  iss_t       skid_q [2];
  logic [1:0] skid_cnt;
  logic [1:0] skid_cnt_nxt;
  logic       in_ready_q;
  logic       out_free;
  logic       load_skid;
  logic       load_direct;
  logic       push;
  logic [1:0] push_pos;

  assign in_ready     = in_ready_q;
  assign accept       = in_valid && in_ready_q;
  assign out_free     = !out_valid || out_ready;
  assign load_skid    = out_free && (skid_cnt != 2'd0);
  assign load_direct  = out_free && (skid_cnt == 2'd0) && accept;
  assign push         = accept && !load_direct;
  assign push_pos     = skid_cnt - {1'b0, load_skid};
  assign skid_cnt_nxt = skid_cnt + {1'b0, push} - {1'b0, load_skid};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      out_q.pc   <= RESET_PC;
      skid_cnt   <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      skid_cnt   <= skid_cnt_nxt;
      // Drops the cycle the second skid slot fills; never admits a third.
      in_ready_q <= (skid_cnt_nxt != 2'd2);
      if (load_skid) begin
        out_valid <= 1'b1;
        out_q     <= skid_q[0];
      end else if (load_direct) begin
        out_valid <= 1'b1;
        out_q     <= dec;
      end else if (out_valid && out_ready) begin
        out_valid     <= 1'b0;
        out_q.op      <= '0;
        out_q.illegal <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset: skid_cnt alone says what is live.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_q[0] <= skid_q[1];
    end
    // When popping and pushing at one entry, the new entry lands in slot 0
    // after the shift; this later assignment wins over the shift above.
    if (push) begin
      skid_q[push_pos[0]] <= dec;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      out_q.pc  <= RESET_PC;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_q     <= dec;
    end else if (out_valid && out_ready) begin
      out_valid     <= 1'b0;
      out_q.op      <= '0;
      out_q.illegal <= 1'b0;
    end
  end
`endif

  assign reg_op1     = out_q.op1;
  assign reg_op2     = out_q.op2;
  assign out_op      = out_q.op;
  assign out_br_imm  = out_q.br_imm;
  assign out_pc      = out_q.pc;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_rv32_alu_issue.sv
// Bench for rv32_alu_issue: scoreboard of hand-derived expectations per instruction.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
// Covers reset, directed decode cases, stall stability, async reset mid-stall, random backpressure.
module tb_rv32_alu_issue;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] reg_op1;
  logic [31:0] reg_op2;
  logic [15:0] out_op;
  logic [31:0] out_br_imm;
  logic [31:0] out_pc;
  logic        out_illegal;

  rv32_alu_issue #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_op1(reg_op1), .reg_op2(reg_op2), .out_op(out_op), .out_br_imm(out_br_imm),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    int          idx;   // expected one-hot bit, -1 for illegal
    logic [31:0] op2;
    logic [31:0] br;
    bit          alu;   // also check the SRA result of T2
  } vec_t;

  typedef struct {
    logic [15:0] op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] br;
    logic [31:0] pc;
    logic        ill;
    bit          alu;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t cur_exp;
  int   n_checks = 0;
  int   n_errors = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'h33};
  endfunction

  function automatic logic [31:0] ii(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd3, 7'h13};
  endfunction

  function automatic logic [31:0] bb(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] rs1,
                               input logic [31:0] rs2, input int idx,
                               input logic [31:0] op2, input logic [31:0] br, input bit alu);
    vec_t v;
    v.instr = instr; v.rs1 = rs1; v.rs2 = rs2; v.idx = idx;
    v.op2 = op2; v.br = br; v.alu = alu;
    return v;
  endfunction

  function automatic exp_t mk_exp(input vec_t v, input logic [31:0] pc);
    exp_t e;
    e.op  = '0;
    if (v.idx >= 0) e.op[v.idx] = 1'b1;
    e.op1 = v.rs1;
    e.op2 = v.op2;
    e.br  = v.br;
    e.pc  = pc;
    e.ill = (v.idx < 0);
    e.alu = v.alu;
    return e;
  endfunction

  // Present one instruction and hold it until accepted (bounded).
  task automatic send(input vec_t v, input logic [31:0] pc);
    logic acc;
    cur_exp     = mk_exp(v, pc);
    in_valid    = 1'b1;
    in_instr    = v.instr;
    in_pc       = pc;
    in_rs1_data = v.rs1;
    in_rs2_data = v.rs2;
    acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_instr    = 'x;
    in_pc       = 'x;
    in_rs1_data = 'x;
    in_rs2_data = 'x;
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard monitor: both handshakes are decided by values stable at the falling edge.
  logic [31:0] alu_res;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("op", 32'(out_op), 32'(e.op));
          check("illegal", 32'(out_illegal), 32'(e.ill));
          check("op1", reg_op1, e.op1);
          check("pc", out_pc, e.pc);
          if (!e.ill) begin
            check("op2", reg_op2, e.op2);
            check("br_imm", out_br_imm, e.br);
          end
          if (e.alu) begin
            alu_res = $signed(reg_op1) >>> reg_op2[4:0];
            check("t2_sra_result", alu_res, 32'hFF00_0000);
          end
        end
      end
      if (!out_valid) check("op_idle_zero", 32'(out_op), 32'd0);
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  logic [144:0] snap;
  logic [144:0] now_v;
  logic         got;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed T1..T4
    vecs.push_back(mkv(32'h003100B3, 32'd5, 32'd3, 0, 32'd3, 32'd0, 1'b0));
    vecs.push_back(mkv(32'h40415093, 32'hF000_0000, 32'h1234_5678, 7, 32'd4, 32'd0, 1'b1));
    vecs.push_back(mkv(32'h0020F463, 32'h8000_0000, 32'd1, 15, 32'd1, 32'd8, 1'b0));
    vecs.push_back(mkv(32'h0000007F, 32'd7, 32'd9, -1, 32'd0, 32'd0, 1'b0));
    // Register-register
    vecs.push_back(mkv(rr(7'h20, 3'b000), 32'd10, 32'd4, 1, 32'd4, 32'd0, 1'b0));
    vecs.push_back(mkv(rr(7'h00, 3'b111), 32'hA5A5_0001, 32'd7, 2, 32'd7, 32'd0, 1'b0));
    vecs.push_back(mkv(rr(7'h00, 3'b110), 32'hA5A5_0002, 32'd8, 3, 32'd8, 32'd0, 1'b0));
    vecs.push_back(mkv(rr(7'h00, 3'b100), 32'hA5A5_0003, 32'd9, 4, 32'd9, 32'd0, 1'b0));
    vecs.push_back(mkv(rr(7'h00, 3'b001), 32'h0000_0011, 32'd2, 5, 32'd2, 32'd0, 1'b0));
    vecs.push_back(mkv(rr(7'h00, 3'b101), 32'h8000_0000, 32'd3, 6, 32'd3, 32'd0, 1'b0));
    vecs.push_back(mkv(rr(7'h20, 3'b101), 32'h8000_0000, 32'd3, 7, 32'd3, 32'd0, 1'b0));
    vecs.push_back(mkv(rr(7'h00, 3'b010), 32'hFFFF_FFFF, 32'd1, 8, 32'd1, 32'd0, 1'b0));
    vecs.push_back(mkv(rr(7'h00, 3'b011), 32'd1, 32'hFFFF_FFFF, 9, 32'hFFFF_FFFF, 32'd0, 1'b0));
    vecs.push_back(mkv(rr(7'h01, 3'b000), 32'd6, 32'd6, -1, 32'd0, 32'd0, 1'b0));
    vecs.push_back(mkv(rr(7'h20, 3'b111), 32'd6, 32'd6, -1, 32'd0, 32'd0, 1'b0));
    // Immediate forms
    vecs.push_back(mkv(ii(12'hFFB, 3'b000), 32'd20, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFB, 32'd0, 1'b0));
    vecs.push_back(mkv(ii(12'h800, 3'b010), 32'd21, 32'hDEAD_BEEF, 8, 32'hFFFF_F800, 32'd0, 1'b0));
    vecs.push_back(mkv(ii(12'h001, 3'b011), 32'd22, 32'hDEAD_BEEF, 9, 32'd1, 32'd0, 1'b0));
    vecs.push_back(mkv(ii(12'h7FF, 3'b100), 32'd23, 32'hDEAD_BEEF, 4, 32'h0000_07FF, 32'd0, 1'b0));
    vecs.push_back(mkv(ii(12'h400, 3'b110), 32'd24, 32'hDEAD_BEEF, 3, 32'h0000_0400, 32'd0, 1'b0));
    vecs.push_back(mkv(ii(12'hF0F, 3'b111), 32'd25, 32'hDEAD_BEEF, 2, 32'hFFFF_FF0F, 32'd0, 1'b0));
    vecs.push_back(mkv(ii({7'h00, 5'd31}, 3'b001), 32'd1, 32'hDEAD_BEEF, 5, 32'd31, 32'd0, 1'b0));
    vecs.push_back(mkv(ii({7'h00, 5'd1}, 3'b101), 32'd2, 32'hDEAD_BEEF, 6, 32'd1, 32'd0, 1'b0));
    vecs.push_back(mkv(ii({7'h20, 5'd1}, 3'b001), 32'd3, 32'hDEAD_BEEF, -1, 32'd0, 32'd0, 1'b0));
    vecs.push_back(mkv(ii({7'h01, 5'd1}, 3'b101), 32'd4, 32'hDEAD_BEEF, -1, 32'd0, 32'd0, 1'b0));
    // Branches
    vecs.push_back(mkv(bb(13'h1FF0, 3'b000), 32'd30, 32'd31, 10, 32'd31, 32'hFFFF_FFF0, 1'b0));
    vecs.push_back(mkv(bb(13'h0FFE, 3'b001), 32'd32, 32'd33, 11, 32'd33, 32'h0000_0FFE, 1'b0));
    vecs.push_back(mkv(bb(13'h0800, 3'b100), 32'd34, 32'd35, 12, 32'd35, 32'h0000_0800, 1'b0));
    vecs.push_back(mkv(bb(13'h1000, 3'b101), 32'd36, 32'd37, 13, 32'd37, 32'hFFFF_F000, 1'b0));
    vecs.push_back(mkv(bb(13'h0004, 3'b110), 32'd38, 32'd39, 14, 32'd39, 32'h0000_0004, 1'b0));
    vecs.push_back(mkv(bb(13'h0010, 3'b010), 32'd40, 32'd41, -1, 32'd0, 32'd0, 1'b0));
    vecs.push_back(mkv(bb(13'h0010, 3'b011), 32'd42, 32'd43, -1, 32'd0, 32'd0, 1'b0));
    vecs.push_back(mkv(32'h0000_2083, 32'd44, 32'd45, -1, 32'd0, 32'd0, 1'b0));
    vecs.push_back(mkv(32'h0080_006F, 32'd46, 32'd47, -1, 32'd0, 32'd0, 1'b0));

    // Reset state
    rst = 1'b1;
    rdy_mode = 0;
    out_ready = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);
    check("rst_reg_op1", reg_op1, 32'd0);
    check("rst_reg_op2", reg_op2, 32'd0);
    check("rst_br_imm", out_br_imm, 32'd0);
    check("rst_out_pc", out_pc, RST_PC);
    check("rst_illegal", 32'(out_illegal), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // T1..T4 back-to-back with the consumer always ready
    for (int i = 0; i < 4; i++) send(vecs[i], 32'h1000 + 32'(4 * i));
    idle();
    repeat (4) @(posedge clk);
    #1;

    // T5: four back-to-back ops against a stalled consumer
    rdy_mode = 2;
    @(posedge clk);
    #2;
    fork
      begin
        for (int i = 4; i < 8; i++) send(vecs[i], 32'h2000 + 32'(4 * i));
        idle();
      end
      begin
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
          @(negedge clk);
          got = out_valid;
        end
        check("t5_first_valid", 32'(got), 32'd1);
        snap = {out_op, reg_op1, reg_op2, out_br_imm, out_pc, out_illegal};
        for (int j = 0; j < 3; j++) begin
          if (j > 0) @(negedge clk);
          now_v = {out_op, reg_op1, reg_op2, out_br_imm, out_pc, out_illegal};
          if (j > 0) check("t5_stable", 32'(now_v === snap), 32'd1);
          check("t5_valid_held", 32'(out_valid), 32'd1);
`ifdef ALU_ISSUE_SKID_EN
          check("t5_in_ready", 32'(in_ready), (j < 2) ? 32'd1 : 32'd0);
`else
          check("t5_in_ready", 32'(in_ready), 32'd0);
`endif
        end
        rdy_mode = 0;
      end
    join
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      got = (sb.size() == 0);
    end
    check("t5_drained", 32'(got), 32'd1);

    // T6: asynchronous reset while an entry is stalled at the output
    rdy_mode = 2;
    @(posedge clk);
    #2;
    send(vecs[0], 32'h3000);
    idle();
    @(negedge clk);
    check("t6_valid_before_rst", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_op", 32'(out_op), 32'd0);
    check("t6_async_pc", out_pc, RST_PC);
    check("t6_async_op1", reg_op1, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    check("t6_dropped", 32'(out_valid), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);

    // Whole table with random gaps and random consumer backpressure
    rdy_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i], 32'h4000 + 32'(4 * i));
      if ($urandom_range(3) == 0) begin
        idle();
        @(posedge clk);
        #1;
      end
    end
    idle();
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      got = (sb.size() == 0) && !out_valid;
    end
    check("final_drain", 32'(got), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
